// File: rtl/window_gen_3x3_pkg.sv
// Shared constants, FSM encoding and width helper for the 3x3 window generator.
package window_gen_3x3_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_N = 9;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  // Bits needed to address v entries (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, window stream out.
interface window_gen_3x3_if;
  import window_gen_3x3_pkg::*;
  logic [PIX_W-1:0]       in_pixel;
  logic                   in_valid;
  logic [WIN_N*PIX_W-1:0] pixel_data;
  logic                   pixel_data_valid;
  logic                   frame_done;

  modport master (output in_pixel, in_valid,
                  input  pixel_data, pixel_data_valid, frame_done);
  modport slave  (input  in_pixel, in_valid,
                  output pixel_data, pixel_data_valid, frame_done);
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One line of pixels: synchronous write, combinational read, never reset.
module line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  // Write the new entry; read returns the pre-write value this cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic clk,
  input  logic rst,
  window_gen_3x3_if.slave io
);
  localparam int CW = clog2(IMG_WIDTH);
  localparam int RW = clog2(IMG_HEIGHT);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  state_t           state_q;
  // [r][c][bit]: flattening gives byte index 3*r + c directly.
  logic [2:0][2:0][PIX_W-1:0] sr_q, sr_d;
  logic [WIN_N*PIX_W-1:0]     data_q;
  logic             vld_q, done_q;
  logic [PIX_W-1:0] l1_rd, l2_rd;
  logic             last_col, last_row, we;

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
  // A pixel arriving during reset is dropped, so it must not touch the RAMs.
  assign we       = io.in_valid & ~rst;

  // Line N-1 takes the new pixel; line N-2 takes what line N-1 held.
  line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk(clk), .we_i(we), .addr_i(col_q), .wdata_i(io.in_pixel), .rdata_o(l1_rd));
  line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb2 (
    .clk(clk), .we_i(we), .addr_i(col_q), .wdata_i(l1_rd), .rdata_o(l2_rd));

  // Column shift: oldest column drops out of c=0, new column enters at c=2.
  always_comb begin
    sr_d = sr_q;
    if (io.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = sr_q[r][2];
      end
      sr_d[0][2] = l2_rd;
      sr_d[1][2] = l1_rd;
      sr_d[2][2] = io.in_pixel;
    end
  end

  // Counters, FILL/RUN control and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
      sr_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (io.in_valid) begin
        sr_q   <= sr_d;
        col_q  <= last_col ? '0 : col_q + CW'(1);
        if (last_col) row_q <= last_row ? '0 : row_q + RW'(1);
        done_q <= last_col & last_row;
        case (state_q)
          FILL: if (last_col && row_q == RW'(1)) state_q <= RUN;
          RUN: begin
            // First two columns of a line would mix in the previous line.
            if (col_q >= CW'(2)) begin
              vld_q  <= 1'b1;
              data_q <= sr_d;
            end
            if (last_col && last_row) state_q <= FILL;
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign io.pixel_data       = data_q;
  assign io.pixel_data_valid = vld_q;
  assign io.frame_done       = done_q;
endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 512, pixels per line (range 3..4096).
REQ-002 Parameter IMG_HEIGHT, default 512, lines per frame (range 3..4096).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_pixel  input  8  raster-order grayscale pixel.
REQ-006 in_valid  input  1  in_pixel is valid this cycle; gaps of any length are allowed; there is no backpressure.
REQ-007 pixel_data  output  72  3x3 window; byte i = pixel_data[i*8+:8], i = 3*r + c.
  - r = 0: oldest line (top).
  - c = 0: oldest column (left).
REQ-008 pixel_data_valid  output  1  pixel_data holds a complete window this cycle.
REQ-009 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-010 The block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1); both advance only on in_valid.
REQ-011 On an accepted pixel with col == IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-012 On an accepted pixel with col == IMG_WIDTH-1 and row == IMG_HEIGHT-1, both counters SHALL wrap to 0 and frame_done SHALL pulse on the next cycle.
REQ-013 The block SHALL store the two previous lines in two line buffers of IMG_WIDTH x 8 bits, addressed by col.
  - Each accepted pixel SHALL read the line N-1 and line N-2 entries at col.
  - In the same cycle it SHALL write in_pixel into line N-1 and the old line N-1 value into line N-2.
REQ-014 Three 3-byte column shift registers (rows r = 0..2) SHALL shift only on in_valid.
  - Row 2 SHALL receive in_pixel.
  - Row 1 SHALL receive the line N-1 read value.
  - Row 0 SHALL receive the line N-2 read value.
REQ-015 FSM states:
  - FILL: row < 2.
  - RUN: row >= 2.
  - FILL -> RUN when a pixel is accepted with col == IMG_WIDTH-1 and row == 1.
  - RUN -> FILL at frame wrap (REQ-012).
REQ-016 In RUN, an accepted pixel with col >= 2 SHALL drive pixel_data_valid = 1 on the next cycle, with the window centred on input pixel (row-1, col-1).
REQ-017 In every other case pixel_data_valid SHALL be 0; pixel_data SHALL hold its last value while pixel_data_valid is 0.
REQ-018 Latency SHALL be exactly one clock from the accepted pixel to pixel_data_valid; outputs SHALL be registered.
REQ-019 Each frame SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-020 Windows SHALL never straddle lines: the first two pixels of each line produce no output.
REQ-021 Line-buffer contents SHALL carry across frames; FILL suppresses all output that would contain stale data.
REQ-022 A frame-wrap pixel SHALL produce its last window and frame_done on the same following cycle.

Reset
REQ-023 While rst is high, the block SHALL drive col = 0, row = 0, state = FILL, pixel_data_valid = 0 and frame_done = 0.
REQ-024 While rst is high, pixel_data and the column shift registers SHALL be cleared to 0.
REQ-025 Line-buffer RAM contents SHALL NOT be cleared by reset.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no frame_done; the next accepted pixel is (0,0) of a new frame.
REQ-027 rst SHALL take priority over a simultaneous in_valid, and that pixel SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold PIX_W = 8, WIN_N = 9, the FSM state encoding (FILL, RUN) and the counter-width function clog2.
REQ-029 One sub-module, line_buffer (IMG_WIDTH x 8, synchronous write, combinational read), SHALL be instantiated twice.

Verification
Bench parameters: IMG_WIDTH = 8, IMG_HEIGHT = 6, pixel value = 16*row + col, unless stated otherwise.
REQ-030 Continuous valid stream -> the first pixel_data_valid follows input (2,2); bytes 0..8 = 0x00, 0x01, 0x02, 0x10, 0x11, 0x12, 0x20, 0x21, 0x22.
REQ-031 Full frame -> exactly 24 windows and one frame_done, coincident with the window whose bytes 0..8 = 0x35..0x37, 0x45..0x47, 0x55..0x57 (last bytes 0x55, 0x56, 0x57).
REQ-032 Same frame with in_valid toggling 1-0-1-0 -> identical window sequence, each window one cycle after its pixel, pixel_data_valid never on an idle-input cycle.
REQ-033 Two back-to-back frames, second frame = first + 0x80 -> second frame's first window = 0x80, 0x81, 0x82, 0x90, 0x91, 0x92, 0xA0, 0xA1, 0xA2; no window in its FILL rows.
REQ-034 rst pulsed at input (3,4), then a fresh frame -> no frame_done for the aborted frame; the first window of the new frame follows its (2,2) pixel with correct bytes.
REQ-035 IMG_WIDTH = 3, IMG_HEIGHT = 3, values 1..9 -> exactly one window with bytes 0..8 = 1..9, plus frame_done.
